// File: rtl/aes_pkg.sv
// Shared AES types and helpers: 128-bit state, 32-bit column word, byte access.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  localparam int AES_BYTES = 16;

  // Byte 0 (s0: row0,col0) sits in bits [127:120]; bytes run down column by column.
  function automatic logic [7:0] byte_of(input state_t s, input int idx);
    return s[127 - 8*idx -: 8];
  endfunction

endpackage

// File: rtl/add_round_key_if.sv
// Bus between a round stage and AddRoundKey: qualified Msg/Key in, registered result out.
// Handshake: in_valid=1 qualifies Msg/Key for exactly that cycle, out_valid=1 qualifies result;
// there is no ready, so every valid beat is accepted and every output beat must be consumed when shown.
interface add_round_key_if;
  import aes_pkg::*;

  logic   in_valid;
  state_t Msg;
  state_t Key;
  state_t result;
  logic   out_valid;

  modport master (output in_valid, Msg, Key, input result, out_valid);
  modport slave  (input in_valid, Msg, Key, output result, out_valid);
endinterface

// File: rtl/add_round_key_col.sv
// One 32-bit state column XORed with its round-key column, four independent byte lanes.
module add_round_key_col
  import aes_pkg::*;
(
  input  word_t msg_i,
  input  word_t key_i,
  output word_t result_o
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign result_o[8*b +: 8] = msg_i[8*b +: 8] ^ key_i[8*b +: 8];
  end

endmodule

// File: rtl/add_round_key.sv
// AES-128 AddRoundKey: result = Msg ^ Key through a STAGES-deep registered pipeline with valid.
module add_round_key
  import aes_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic           clk,
  input  logic           rst,
  add_round_key_if.slave bus
);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("add_round_key: STAGES must be 1 or 2");
  end

  state_t xor_d;

  // Column c covers bits [127-32c -: 32], i.e. column 0 holds s0..s3.
  for (genvar c = 0; c < 4; c++) begin : g_col
    add_round_key_col u_col (
      .msg_i    (bus.Msg[127 - 32*c -: 32]),
      .key_i    (bus.Key[127 - 32*c -: 32]),
      .result_o (xor_d[127 - 32*c -: 32])
    );
  end

  state_t [STAGES-1:0] data_q;
  state_t [STAGES-1:0] data_d;
  logic   [STAGES-1:0] valid_q;
  logic   [STAGES-1:0] valid_d;

  always_comb begin
    data_d     = '0;
    valid_d    = '0;
    data_d[0]  = xor_d;
    valid_d[0] = bus.in_valid;
    for (int s = 1; s < STAGES; s++) begin
      data_d[s]  = data_q[s-1];
      valid_d[s] = valid_q[s-1];
    end
  end

  // Valid shifts every cycle; data only moves with its valid so result holds between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < STAGES; s++) begin
        if (valid_d[s]) data_q[s] <= data_d[s];
      end
    end
  end

  assign bus.result    = data_q[STAGES-1];
  assign bus.out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key: reset, FIPS-197 vector, identities, streaming, hold, mid-burst reset.
module tb_add_round_key;
  import aes_pkg::*;

  localparam int STAGES = 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [127:0] exp_q[$];

  add_round_key_if bus ();

  add_round_key #(.STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_xor(input state_t m, input state_t k);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < AES_BYTES; i++) r[127 - 8*i -: 8] = byte_of(m, i) ^ byte_of(k, i);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic v, input logic [127:0] m, input logic [127:0] k);
    bus.in_valid = v;
    bus.Msg      = m;
    bus.Key      = k;
  endtask

  task automatic send_one(input string tag, input logic [127:0] m, input logic [127:0] k,
                          input logic [127:0] exp);
    drive(1'b1, m, k);
    step();
    drive(1'b0, rand128(), rand128());
    for (int i = 1; i < STAGES; i++) begin
      check({tag, "_early_valid"}, {127'd0, bus.out_valid}, 128'd0);
      step();
    end
    check({tag, "_valid"}, {127'd0, bus.out_valid}, 128'd1);
    check({tag, "_result"}, bus.result, exp);
    step();
    check({tag, "_valid_drop"}, {127'd0, bus.out_valid}, 128'd0);
  endtask

  // Driver / scoreboard
  initial begin
    logic [127:0] m;
    logic [127:0] k;
    logic [127:0] last;
    int n_out;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, 128'ha0fafe1788542cb123a339392a6c7605);

    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_result", bus.result, 128'd0);
      check("reset_valid", {127'd0, bus.out_valid}, 128'd0);
    end
    drive(1'b0, '0, '0);
    rst = 1'b0;
    step();
    check("post_reset_idle_valid", {127'd0, bus.out_valid}, 128'd0);

    send_one("fips_round1", 128'h046681e5e0cb199a48f8d37a2806264c,
             128'ha0fafe1788542cb123a339392a6c7605, 128'ha49c7ff2689f352b6b5bea43026a5049);
    send_one("zero_zero", 128'd0, 128'd0, 128'd0);
    send_one("msg_eq_key", {4{32'hdeadbeef}}, {4{32'hdeadbeef}}, 128'd0);
    send_one("key_zero", 128'h00112233445566778899aabbccddeeff, 128'd0,
             128'h00112233445566778899aabbccddeeff);
    send_one("invert", {128{1'b1}}, 128'h0123456789abcdeffedcba9876543210,
             128'hfedcba98765432100123456789abcdef);

    // Streaming: four back-to-back beats, checked in order against the queue.
    n_out = 0;
    last  = '0;
    for (int cyc = 0; cyc < 4 + STAGES + 2; cyc++) begin
      if (cyc < 4) begin
        m = rand128();
        k = rand128();
        drive(1'b1, m, k);
        exp_q.push_back(model_xor(m, k));
        last = model_xor(m, k);
      end else begin
        drive(1'b0, rand128(), rand128());
      end
      step();
      if (bus.out_valid) begin
        n_out++;
        if (exp_q.size() == 0) check("stream_extra_beat", {127'd0, bus.out_valid}, 128'd0);
        else check("stream_beat", bus.result, exp_q.pop_front());
      end
    end
    check("stream_count", 128'(n_out), 128'd4);
    check("stream_drained", 128'(exp_q.size()), 128'd0);

    // Hold: result keeps the last beat while idle.
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_result", bus.result, last);
      check("hold_valid", {127'd0, bus.out_valid}, 128'd0);
    end

    // Mid-burst reset: two beats, then rst flushes the pipe.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand128(), rand128());
      step();
    end
    drive(1'b1, rand128(), rand128());
    rst = 1'b1;
    step();
    check("midrst_result", bus.result, 128'd0);
    check("midrst_valid", {127'd0, bus.out_valid}, 128'd0);
    rst = 1'b0;
    drive(1'b0, rand128(), rand128());
    for (int i = 0; i < STAGES + 2; i++) begin
      step();
      check("midrst_flush_valid", {127'd0, bus.out_valid}, 128'd0);
      check("midrst_flush_result", bus.result, 128'd0);
    end

    m = 128'h3243f6a8885a308d313198a2e0370734;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    send_one("post_reset_fresh", m, k, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
